// File: rtl/fifo_stream_drain_if.sv
// Bundles the FIFO read port and the valid/ready output stream of fifo_stream_drain.
// The master modport is the drain itself; slave is the FIFO plus downstream sink.
interface fifo_stream_drain_if #(
    parameter int DATA_WIDTH = 64,
    parameter int PKT_LEN    = 8
);
    localparam int CNT_WIDTH = $clog2(PKT_LEN + 1);

    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic [CNT_WIDTH-1:0]  beat_cnt;

    modport master (
        input  fifo_dout,
        input  fifo_empty,
        input  out_ready,
        output fifo_rd_en,
        output out_valid,
        output out_data,
        output out_last,
        output beat_cnt
    );

    modport slave (
        output fifo_dout,
        output fifo_empty,
        output out_ready,
        input  fifo_rd_en,
        input  out_valid,
        input  out_data,
        input  out_last,
        input  beat_cnt
    );
endinterface

// File: rtl/fifo_stream_drain.sv
// Drains a sync FIFO with 1-cycle read latency into a valid/ready stream,
// using a 2-entry skid buffer and credit-based read issue; frames packets of PKT_LEN beats.
module fifo_stream_drain #(
    parameter int DATA_WIDTH = 64,
    parameter int PKT_LEN    = 8
) (
    input  logic                 clock,
    input  logic                 rst,
    fifo_stream_drain_if.master  io
);
    localparam int                   CNT_WIDTH = $clog2(PKT_LEN + 1);
    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(PKT_LEN - 1);

    logic [DATA_WIDTH-1:0] buf_mem [2];
    logic                  head;
    logic                  tail;
    logic [1:0]            occ;
    logic                  vld_p1;
    logic [CNT_WIDTH-1:0]  beat_cnt;
    logic                  pop;
    logic                  last_beat;
    logic                  rd_en_p0;
    logic [2:0]            credit_used;

    function automatic logic [CNT_WIDTH-1:0] next_beat(input logic [CNT_WIDTH-1:0] cnt);
        return (cnt == LAST_BEAT) ? '0 : cnt + 1'b1;
    endfunction

    function automatic logic [1:0] next_occ(input logic [1:0] cur, input logic cap, input logic take);
        logic [1:0] res;
        res = cur;
        if (cap && !take)
            res = cur + 2'd1;
        else if (!cap && take)
            res = cur - 2'd1;
        return res;
    endfunction

    // p0: read issue. A slot is reserved for every word already buffered or still in flight.
    always_comb begin
        pop         = (occ != 2'd0) && io.out_ready;
        credit_used = {1'b0, occ} + {2'b00, vld_p1} - {2'b00, pop};
        rd_en_p0    = rst && !io.fifo_empty && (credit_used < 3'd2);
    end

    // p1: the word requested last cycle arrives on fifo_dout and lands at the tail.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            vld_p1   <= 1'b0;
            occ      <= 2'd0;
            head     <= 1'b0;
            tail     <= 1'b0;
            beat_cnt <= '0;
        end else begin
            vld_p1 <= rd_en_p0;
            occ    <= next_occ(occ, vld_p1, pop);
            if (vld_p1)
                tail <= ~tail;
            if (pop) begin
                head     <= ~head;
                beat_cnt <= next_beat(beat_cnt);
            end
        end
    end

    // Buffer contents carry no reset; occ alone decides what is meaningful.
    always_ff @(posedge clock) begin
        if (vld_p1)
            buf_mem[tail] <= io.fifo_dout;
    end

    // p2: output presentation straight from the buffer head.
    always_comb begin
        last_beat     = (occ != 2'd0) && (beat_cnt == LAST_BEAT);
        io.fifo_rd_en = rd_en_p0;
        io.out_valid  = (occ != 2'd0);
        io.out_data   = (occ != 2'd0) ? buf_mem[head] : '0;
        io.out_last   = last_beat;
        io.beat_cnt   = beat_cnt;
    end

    occ_bound: assert property (@(posedge clock) disable iff (!rst) occ != 2'd3);

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Randomized and directed bench for fifo_stream_drain with a FIFO model and a
// count-based scoreboard derived from the read-latency and credit rules.
module tb_fifo_stream_drain;
    localparam int DW = 64;
    localparam int PL = 8;
    localparam int CW = $clog2(PL + 1);

    logic clock = 1'b0;
    logic rst   = 1'b1;
    always #5 clock = ~clock;

    fifo_stream_drain_if #(.DATA_WIDTH(DW), .PKT_LEN(PL)) bus ();
    fifo_stream_drain_if #(.DATA_WIDTH(DW), .PKT_LEN(1))  bus1 ();

    fifo_stream_drain #(.DATA_WIDTH(DW), .PKT_LEN(PL)) dut (
        .clock (clock),
        .rst   (rst),
        .io    (bus)
    );

    fifo_stream_drain #(.DATA_WIDTH(DW), .PKT_LEN(1)) dut1 (
        .clock (clock),
        .rst   (rst),
        .io    (bus1)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] eq[$];
    logic [DW-1:0] pushed[$];
    logic [DW-1:0] got[$];
    bit            got_last[$];
    int            pop_cyc[$];
    int            rd_cyc[$];
    int            n_reads;
    int            n_pops;
    bit            rd_prev;

    task automatic clear_model();
        fq.delete(); eq.delete(); pushed.delete();
        got.delete(); got_last.delete(); pop_cyc.delete(); rd_cyc.delete();
        n_reads = 0; n_pops = 0; rd_prev = 1'b0;
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        fq.push_back(w);
        pushed.push_back(w);
        bus.fifo_empty = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_model();
        bus.fifo_empty = 1'b1;
        bus.fifo_dout  = '0;
        bus.out_ready  = 1'b0;
        repeat (2) @(posedge clock);
        #1 rst = 1'b1;
    endtask

    // One clock of the environment: FIFO model, sink, and scoreboard.
    task automatic step();
        int            outstanding;
        int            avail;
        bit            exp_valid, exp_pop, exp_rd, exp_last, act_pop, act_rd;
        logic [CW-1:0] exp_cnt;
        logic [DW-1:0] word;
        word = '0;
        @(negedge clock);
        outstanding = n_reads - n_pops;
        avail       = outstanding - (rd_prev ? 1 : 0);
        exp_valid   = (avail > 0);
        exp_pop     = exp_valid && (bus.out_ready == 1'b1);
        exp_rd      = (fq.size() != 0) && ((outstanding - (exp_pop ? 1 : 0)) < 2);
        exp_last    = exp_valid && ((n_pops % PL) == PL - 1);
        exp_cnt     = CW'(n_pops % PL);
        checks++;
        if (bus.out_valid !== exp_valid) begin
            errors++; $display("FAIL out_valid cyc=%0d: got %b expected %b", cyc, bus.out_valid, exp_valid);
        end
        checks++;
        if (bus.fifo_rd_en !== exp_rd) begin
            errors++; $display("FAIL fifo_rd_en cyc=%0d: got %b expected %b", cyc, bus.fifo_rd_en, exp_rd);
        end
        checks++;
        if (bus.out_last !== exp_last) begin
            errors++; $display("FAIL out_last cyc=%0d: got %b expected %b", cyc, bus.out_last, exp_last);
        end
        checks++;
        if (bus.beat_cnt !== exp_cnt) begin
            errors++; $display("FAIL beat_cnt cyc=%0d: got %0d expected %0d", cyc, bus.beat_cnt, exp_cnt);
        end
        if (exp_valid && eq.size() > 0) begin
            checks++;
            if (bus.out_data !== eq[0]) begin
                errors++; $display("FAIL out_data cyc=%0d: got %h expected %h", cyc, bus.out_data, eq[0]);
            end
        end
        act_pop = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b1);
        act_rd  = (bus.fifo_rd_en === 1'b1);
        if (act_pop) begin
            got.push_back(bus.out_data);
            got_last.push_back(bus.out_last);
            pop_cyc.push_back(cyc);
            if (eq.size() > 0) void'(eq.pop_front());
            n_pops++;
        end
        if (act_rd) begin
            rd_cyc.push_back(cyc);
            if (fq.size() == 0) begin
                checks++; errors++;
                $display("FAIL read_on_empty cyc=%0d: got rd_en 1 expected 0", cyc);
                act_rd = 1'b0;
            end else begin
                word = fq.pop_front();
                eq.push_back(word);
                n_reads++;
            end
        end
        rd_prev = act_rd;
        cyc++;
        @(posedge clock);
        #1;
        if (act_rd) bus.fifo_dout = word;
        bus.fifo_empty = (fq.size() == 0);
    endtask

    task automatic test_reset();
        bus.fifo_empty = 1'b1; bus.fifo_dout = '0; bus.out_ready = 1'b0;
        bus1.fifo_empty = 1'b1; bus1.fifo_dout = '0; bus1.out_ready = 1'b0;
        #1 rst = 1'b0;
        clear_model();
        bus.fifo_empty = 1'b0;
        bus.out_ready  = 1'b1;
        @(negedge clock);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", bus.out_valid); end
        checks++;
        if (bus.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en: got %b expected 0", bus.fifo_rd_en); end
        checks++;
        if (bus.out_last !== 1'b0) begin errors++; $display("FAIL rst_last: got %b expected 0", bus.out_last); end
        checks++;
        if (bus.out_data !== '0) begin errors++; $display("FAIL rst_data: got %h expected 0", bus.out_data); end
        checks++;
        if (bus.beat_cnt !== '0) begin errors++; $display("FAIL rst_beat_cnt: got %0d expected 0", bus.beat_cnt); end
        bus.fifo_empty = 1'b1;
        @(posedge clock);
        #1 rst = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_stream();
        int start;
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) push_word(DW'(8'h10 + i));
        start = cyc;
        repeat (12) step();
        checks++;
        if (rd_cyc.size() != 8) begin errors++; $display("FAIL stream_reads: got %0d expected 8", rd_cyc.size()); end
        checks++;
        if (got.size() != 8) begin errors++; $display("FAIL stream_beats: got %0d expected 8", got.size()); end
        if (rd_cyc.size() == 8 && got.size() == 8) begin
            checks++;
            if (rd_cyc[0] != start) begin errors++; $display("FAIL stream_first_rd: got %0d expected %0d", rd_cyc[0], start); end
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (rd_cyc[i] != start + i || pop_cyc[i] != start + 2 + i || got[i] !== DW'(8'h10 + i) || got_last[i] != (i == 7)) begin
                    errors++;
                    $display("FAIL stream_beat%0d: got rd@%0d pop@%0d data %h last %b expected rd@%0d pop@%0d data %h last %b",
                             i, rd_cyc[i], pop_cyc[i], got[i], got_last[i], start + i, start + 2 + i, 8'h10 + i, (i == 7));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_word(DW'(8'h10 + i));
        repeat (6) step();
        checks++;
        if (rd_cyc.size() != 2) begin errors++; $display("FAIL bp_reads: got %0d expected 2", rd_cyc.size()); end
        checks++;
        if (bus.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL bp_rd_en: got %b expected 0", bus.fifo_rd_en); end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== DW'(8'h10)) begin
            errors++; $display("FAIL bp_hold: got valid %b data %h expected valid 1 data 10", bus.out_valid, bus.out_data);
        end
        bus.out_ready = 1'b1;
        repeat (10) step();
        checks++;
        if (got.size() != 6) begin errors++; $display("FAIL bp_count: got %0d expected 6", got.size()); end
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== DW'(8'h10 + i)) begin errors++; $display("FAIL bp_order%0d: got %h expected %h", i, got[i], 8'h10 + i); end
        end
    endtask

    task automatic test_toggle();
        do_reset();
        for (int i = 0; i < 16; i++) push_word({$urandom, $urandom});
        for (int i = 0; i < 60; i++) begin
            bus.out_ready = ~i[0];
            step();
        end
        checks++;
        if (got.size() != 16) begin errors++; $display("FAIL toggle_count: got %0d expected 16", got.size()); end
        for (int i = 0; i < 16 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== pushed[i] || got_last[i] != (i == 7 || i == 15)) begin
                errors++; $display("FAIL toggle_beat%0d: got %h last %b expected %h last %b", i, got[i], got_last[i], pushed[i], (i == 7 || i == 15));
            end
        end
        checks++;
        if (bus.beat_cnt !== '0) begin errors++; $display("FAIL toggle_cnt_end: got %0d expected 0", bus.beat_cnt); end
    endtask

    task automatic test_gap();
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) push_word(DW'(32'h100 + i));
        repeat (12) step();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus.beat_cnt !== CW'(5) || bus.out_valid !== 1'b0) begin
                errors++; $display("FAIL gap_hold%0d: got cnt %0d valid %b expected cnt 5 valid 0", i, bus.beat_cnt, bus.out_valid);
            end
            step();
        end
        for (int i = 0; i < 3; i++) push_word(DW'(32'h200 + i));
        repeat (8) step();
        checks++;
        if (got.size() != 8) begin errors++; $display("FAIL gap_count: got %0d expected 8", got.size()); end
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== pushed[i] || got_last[i] != (i == 7)) begin
                errors++; $display("FAIL gap_beat%0d: got %h last %b expected %h last %b", i, got[i], got_last[i], pushed[i], (i == 7));
            end
        end
        checks++;
        if (bus.beat_cnt !== '0) begin errors++; $display("FAIL gap_cnt_end: got %0d expected 0", bus.beat_cnt); end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) push_word(DW'(8'h40 + i));
        repeat (4) step();
        checks++;
        if (bus.beat_cnt !== CW'(2) || bus.out_valid !== 1'b1 || bus.fifo_rd_en !== 1'b1) begin
            errors++; $display("FAIL ares_pre: got cnt %0d valid %b rd %b expected cnt 2 valid 1 rd 1", bus.beat_cnt, bus.out_valid, bus.fifo_rd_en);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.fifo_rd_en !== 1'b0 || bus.beat_cnt !== '0 || bus.out_last !== 1'b0) begin
            errors++; $display("FAIL ares_async: got valid %b rd %b cnt %0d last %b expected 0 0 0 0", bus.out_valid, bus.fifo_rd_en, bus.beat_cnt, bus.out_last);
        end
        clear_model();
        bus.fifo_empty = 1'b1;
        @(posedge clock);
        #1 rst = 1'b1;
        repeat (5) step();
        checks++;
        if (got.size() != 0) begin errors++; $display("FAIL ares_after: got %0d beats expected 0", got.size()); end
    endtask

    task automatic test_pkt_len_one();
        logic [DW-1:0] q1[$];
        logic [DW-1:0] exp1[$];
        logic [DW-1:0] word;
        int            beats;
        bit            rd;
        do_reset();
        beats = 0;
        for (int i = 0; i < 4; i++) begin
            word = {$urandom, $urandom};
            q1.push_back(word);
            exp1.push_back(word);
        end
        bus1.fifo_empty = 1'b0;
        bus1.out_ready  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            checks++;
            if (bus1.out_last !== bus1.out_valid || bus1.beat_cnt !== 1'b0) begin
                errors++; $display("FAIL p1_frame c=%0d: got last %b cnt %0d expected last %b cnt 0", c, bus1.out_last, bus1.beat_cnt, bus1.out_valid);
            end
            if (bus1.out_valid === 1'b1) begin
                checks++;
                if (beats >= 4 || bus1.out_data !== exp1[beats]) begin
                    errors++; $display("FAIL p1_data%0d: got %h expected %h", beats, bus1.out_data, (beats < 4) ? exp1[beats] : '0);
                end
                beats++;
            end
            rd = (bus1.fifo_rd_en === 1'b1) && (q1.size() > 0);
            if (rd) word = q1.pop_front();
            @(posedge clock);
            #1;
            if (rd) bus1.fifo_dout = word;
            bus1.fifo_empty = (q1.size() == 0);
        end
        checks++;
        if (beats != 4) begin errors++; $display("FAIL p1_count: got %0d expected 4", beats); end
        bus1.out_ready = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 300; c++) begin
            if ($urandom_range(0, 2) == 0) push_word({$urandom, $urandom});
            bus.out_ready = ($urandom_range(0, 9) < 6);
            step();
        end
        bus.out_ready = 1'b1;
        repeat (8) step();
        checks++;
        if (got.size() != pushed.size()) begin errors++; $display("FAIL rand_count: got %0d expected %0d", got.size(), pushed.size()); end
        for (int i = 0; i < got.size() && i < pushed.size(); i++) begin
            if (got[i] !== pushed[i] || got_last[i] != ((i % PL) == PL - 1)) begin
                checks++; errors++;
                $display("FAIL rand_beat%0d: got %h last %b expected %h last %b", i, got[i], got_last[i], pushed[i], ((i % PL) == PL - 1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_toggle();
        test_gap();
        test_async_reset();
        test_pkt_len_one();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
